riscv_dtm_dmi_ctrl: RTL and testbench
=====================================

// Module: riscv_dtm_dmi_ctrl
// PURPOSE
//  Single-edge, parametrised DMI transaction controller for the RISC-V DTM.
//  Sits between the JTAG TAP (DR shift/capture/update done there) and the DM request/response bus.
//  Owns the dtmcs/dmi register semantics: sticky dmistat, busy detection, dmireset, dtmhardreset.
//  Adds an optional response timeout.
// PARAMETERS
//  ABITS           7     DMI address width; reported in dtmcs.abits
//  DATA_WIDTH      32    DMI data width
//  IDLE_CYCLES     1     3-bit hint reported in dtmcs.idle
//  TIMEOUT_CYCLES  1024  cycles in REQ+RESP before abort; used only with the macro
//  Derived: DMI_W = ABITS+DATA_WIDTH+2
// PORTS
//  tck_i          in   1           clock (JTAG TCK), posedge only
//  trst_i         in   1           asynchronous active-high reset
//  dmi_update_i   in   1           1-cycle pulse: Update-DR with dmi selected
//  dmi_capture_i  in   1           1-cycle pulse: Capture-DR with dmi selected
//  dmi_wdata_i    in   DMI_W       shifted dmi value {addr,data,op}
//  dmi_rdata_o    out  DMI_W       value for TAP to load at capture {addr,data,op}
//  dtmcs_update_i in   1           1-cycle pulse: Update-DR with dtmcs selected
//  dtmcs_wdata_i  in   32          shifted dtmcs value
//  dtmcs_rdata_o  out  32          dtmcs read value
//  req_valid_o    out  1           DMI request valid
//  req_ready_i    in   1           DMI request ready
//  req_addr_o     out  ABITS       request address
//  req_data_o     out  DATA_WIDTH  request write data
//  req_op_o       out  2           request op: 1 = read, 2 = write
//  resp_valid_i   in   1           DMI response valid
//  resp_ready_o   out  1           DMI response ready
//  resp_data_i    in   DATA_WIDTH  response data
//  resp_op_i      in   2           response status: 0 = ok, 2 = failed, 3 = busy
// BEHAVIOUR
//  - Reset: state = IDLE, dmistat = 0, req_* = 0, req_valid_o = 0, resp_ready_o = 1;
//    last addr/data = 0, so dmi_rdata_o = 0.
//  - FSM IDLE -> REQ -> RESP -> IDLE.
//    - resp_ready_o = 1 in IDLE and RESP, 0 in REQ.
//    - req_valid_o = 1 only in REQ.
//  - IDLE, dmi_update_i, op in {1,2}, dmistat == 0:
//    - Latch addr/data/op into req_*. Next cycle: REQ.
//    - op 0 or 3: no-op, no request.
//  - REQ: hold req_* stable until req_valid_o & req_ready_i; RESP on the next cycle.
//  - RESP, resp_valid_i:
//    - Latch resp_data_i as last data; return to IDLE.
//    - If dmistat == 0, dmistat <= resp_op_i (0 stays 0; 2 and 3 are sticky).
//  - IDLE with resp_valid_i (stale response): consumed and discarded; last data and dmistat unchanged.
//  - dmistat != 0 and dmi_update_i: update ignored, no request.
//  - Busy: state != IDLE and (dmi_update_i or dmi_capture_i):
//    - dmistat <= 3 (sticky); an update is dropped.
//    - dmi_rdata_o.op shows 3 combinationally while state != IDLE.
//  - dmi_rdata_o in IDLE = {last addr, last data, dmistat}; combinational from registers.
//  - dtmcs_update_i:
//    - bit16 dmireset: dmistat <= 0; FSM untouched.
//    - bit17 dtmhardreset: state <= IDLE, dmistat <= 0, req_valid_o = 0 next cycle.
//  - dtmcs priority: if dtmcs_update_i and dmi_update_i are in the same cycle, dtmcs is applied and
//    dmi_update_i is ignored.
//  - Resolution order within a cycle: hardreset > response completion > busy marking.
//  - dtmcs_rdata_o:
//    - [3:0] = 1, [9:4] = ABITS, [11:10] = dmistat, [14:12] = IDLE_CYCLES.
//    - All other bits 0; bits 16/17 read 0.
//  - trst_i mid-transaction: everything returns to reset values immediately; in-flight request abandoned.
// CONFIGURATION
//  DTM_DMI_TIMEOUT_EN defined:
//   - A counter clears on IDLE -> REQ and increments each cycle in REQ or RESP.
//   - On reaching TIMEOUT_CYCLES: state <= IDLE, req_valid_o = 0 next cycle,
//     dmistat <= 2 if it was 0. A later stale response is discarded.
//  DTM_DMI_TIMEOUT_EN undefined:
//   - No counter; the FSM waits forever. Only dtmhardreset or trst_i recover.
// TESTING
//  1. Write addr 0x10, data 0xDEADBEEF, op 2, req_ready 1 -> req_valid 1 for 1 cycle with those values;
//     resp op 0 -> capture gives op 0, dtmcs[11:10] = 0.
//  2. Read addr 0x11, op 1; resp data 0x12345678, op 0 -> dmi_rdata_o = {0x11, 0x12345678, 0}.
//  3. req_ready 0, capture in REQ -> rdata op 3, dmistat 3; next update op 2 -> no request;
//     dtmcs bit16 -> dmistat 0.
//  4. resp op 2 -> dmistat 2 sticky; next read update produces no req_valid until dmireset.
//  5. dtmcs bit17 in RESP -> IDLE next cycle; late resp_valid data 0xCAFE0000 discarded, last data unchanged.
//  6. TIMEOUT_CYCLES = 16, no resp -> macro on: IDLE at cycle 16, dmistat 2;
//     macro off: still RESP after 1000 cycles.

Source files
------------

// File: rtl/riscv_dtm_dmi_ctrl.sv
// DTM dmi/dtmcs transaction controller: one request in flight, sticky dmistat, busy marking, dmireset/dtmhardreset.
// Request issues 1 cycle after Update-DR; optional response timeout when DTM_DMI_TIMEOUT_EN is defined.
module riscv_dtm_dmi_ctrl #(
    parameter  int ABITS          = 7,
    parameter  int DATA_WIDTH     = 32,
    parameter  int IDLE_CYCLES    = 1,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int DMI_W          = ABITS + DATA_WIDTH + 2
) (
    input  logic                  tck_i,
    input  logic                  trst_i,
    input  logic                  dmi_update_i,
    input  logic                  dmi_capture_i,
    input  logic [DMI_W-1:0]      dmi_wdata_i,
    output logic [DMI_W-1:0]      dmi_rdata_o,
    input  logic                  dtmcs_update_i,
    input  logic [31:0]           dtmcs_wdata_i,
    output logic [31:0]           dtmcs_rdata_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ABITS-1:0]      req_addr_o,
    output logic [DATA_WIDTH-1:0] req_data_o,
    output logic [1:0]            req_op_o,
    input  logic                  resp_valid_i,
    output logic                  resp_ready_o,
    input  logic [DATA_WIDTH-1:0] resp_data_i,
    input  logic [1:0]            resp_op_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_dmistat;
    logic [ABITS-1:0]      r_last_addr;
    logic [DATA_WIDTH-1:0] r_last_data;

    logic       w_hardreset;
    logic       w_dmireset;
    logic       w_dmi_upd;
    logic [1:0] w_wop;
    logic       w_start;
    logic       w_resp_done;
    logic       w_busy;
    logic       w_timeout;
    logic       w_unused_dtmcs;

    assign w_hardreset    = dtmcs_update_i & dtmcs_wdata_i[17];
    assign w_dmireset     = dtmcs_update_i & dtmcs_wdata_i[16];
    assign w_unused_dtmcs = &{1'b0, dtmcs_wdata_i[31:18], dtmcs_wdata_i[15:0]};
    // A dtmcs write in the same cycle swallows the dmi update entirely
    assign w_dmi_upd   = dmi_update_i & ~dtmcs_update_i;
    assign w_wop       = dmi_wdata_i[1:0];
    assign w_start     = (r_state == S_IDLE) & w_dmi_upd & (r_dmistat == 2'd0) &
                         ((w_wop == 2'd1) | (w_wop == 2'd2));
    assign w_resp_done = (r_state == S_RESP) & resp_valid_i & ~w_hardreset;
    assign w_busy      = (r_state != S_IDLE) & (w_dmi_upd | dmi_capture_i);

`ifdef DTM_DMI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_to_cnt;

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            r_to_cnt <= '0;
        end else if (w_start) begin
            r_to_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_to_cnt <= r_to_cnt + CW'(1);
        end
    end

    assign w_timeout = (r_state != S_IDLE) & (r_to_cnt == CW'(TIMEOUT_CYCLES - 1)) & ~w_resp_done;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)      w_state_nxt = S_REQ;
            S_REQ:   if (req_ready_i)  w_state_nxt = S_RESP;
            S_RESP:  if (resp_valid_i) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
        if (w_timeout || w_hardreset) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Resolution: resets first, then response status, then timeout, then busy marking
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            r_dmistat <= 2'd0;
        end else if (w_hardreset || w_dmireset) begin
            r_dmistat <= 2'd0;
        end else if (w_resp_done) begin
            if (r_dmistat == 2'd0) r_dmistat <= resp_op_i;
        end else if (w_timeout) begin
            if (r_dmistat == 2'd0) r_dmistat <= 2'd2;
        end else if (w_busy) begin
            r_dmistat <= 2'd3;
        end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            req_addr_o  <= '0;
            req_data_o  <= '0;
            req_op_o    <= 2'd0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            if (w_start) begin
                req_addr_o  <= dmi_wdata_i[DMI_W-1 -: ABITS];
                req_data_o  <= dmi_wdata_i[2 +: DATA_WIDTH];
                req_op_o    <= w_wop;
                r_last_addr <= dmi_wdata_i[DMI_W-1 -: ABITS];
            end
            if (w_resp_done) begin
                r_last_data <= resp_data_i;
            end
        end
    end

    assign req_valid_o   = (r_state == S_REQ);
    assign resp_ready_o  = (r_state != S_REQ);
    assign dmi_rdata_o   = {r_last_addr, r_last_data, (r_state != S_IDLE) ? 2'd3 : r_dmistat};
    assign dtmcs_rdata_o = {17'd0, 3'(IDLE_CYCLES), r_dmistat, 6'(ABITS), 4'd1};

endmodule

// File: tb/tb_riscv_dtm_dmi_ctrl.sv
// Scenario bench for riscv_dtm_dmi_ctrl; expected requests are queued at update time and checked on handshake.
module tb_riscv_dtm_dmi_ctrl;

    localparam int ABITS = 7;
    localparam int DW    = 32;
    localparam int DMI_W = ABITS + DW + 2;

    typedef logic [DMI_W-1:0] dmi_t;

    logic             tck_i = 1'b0;
    logic             trst_i;
    logic             dmi_update_i;
    logic             dmi_capture_i;
    dmi_t             dmi_wdata_i;
    dmi_t             dmi_rdata_o;
    logic             dtmcs_update_i;
    logic [31:0]      dtmcs_wdata_i;
    logic [31:0]      dtmcs_rdata_o;
    logic             req_valid_o;
    logic             req_ready_i;
    logic [ABITS-1:0] req_addr_o;
    logic [DW-1:0]    req_data_o;
    logic [1:0]       req_op_o;
    logic             resp_valid_i;
    logic             resp_ready_o;
    logic [DW-1:0]    resp_data_i;
    logic [1:0]       resp_op_i;

    dmi_t exp_q[$];
    dmi_t mon_e;
    int   n_run  = 0;
    int   n_fail = 0;
    int   n_fire = 0;

    riscv_dtm_dmi_ctrl #(
        .ABITS(ABITS), .DATA_WIDTH(DW), .IDLE_CYCLES(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .tck_i(tck_i), .trst_i(trst_i),
        .dmi_update_i(dmi_update_i), .dmi_capture_i(dmi_capture_i),
        .dmi_wdata_i(dmi_wdata_i), .dmi_rdata_o(dmi_rdata_o),
        .dtmcs_update_i(dtmcs_update_i), .dtmcs_wdata_i(dtmcs_wdata_i), .dtmcs_rdata_o(dtmcs_rdata_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_op_o(req_op_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_data_i(resp_data_i), .resp_op_i(resp_op_i)
    );

    always #5 tck_i = ~tck_i;

    // Every handshake must match the oldest queued request
    always @(negedge tck_i) begin
        if (!trst_i && req_valid_o && req_ready_i) begin
            n_fire++;
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL req_unexpected got=%h exp=none", {req_addr_o, req_data_o, req_op_o});
            end else begin
                mon_e = exp_q.pop_front();
                if ({req_addr_o, req_data_o, req_op_o} !== mon_e) begin
                    n_fail++;
                    $display("FAIL req_fields got=%h exp=%h", {req_addr_o, req_data_o, req_op_o}, mon_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic dmi_upd(input dmi_t v);
        dmi_wdata_i  = v;
        dmi_update_i = 1'b1;
        tick();
        dmi_update_i = 1'b0;
    endtask

    task automatic dtmcs_wr(input logic [31:0] v);
        dtmcs_wdata_i  = v;
        dtmcs_update_i = 1'b1;
        tick();
        dtmcs_update_i = 1'b0;
        dtmcs_wdata_i  = 32'd0;
    endtask

    task automatic resp(input logic [31:0] d, input logic [1:0] op);
        resp_data_i  = d;
        resp_op_i    = op;
        resp_valid_i = 1'b1;
        tick();
        resp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        trst_i = 1'b1;
        dmi_update_i = 0; dmi_capture_i = 0; dmi_wdata_i = '0;
        dtmcs_update_i = 0; dtmcs_wdata_i = '0;
        req_ready_i = 0; resp_valid_i = 0; resp_data_i = '0; resp_op_i = 0;
        repeat (3) @(negedge tck_i);
        n_run++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", req_valid_o); end
        n_run++; if (resp_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_resp_ready got=%b exp=1", resp_ready_o); end
        n_run++; if (dmi_rdata_o !== '0) begin n_fail++; $display("FAIL rst_dmi_rdata got=%h exp=0", dmi_rdata_o); end
        n_run++; if ({req_addr_o, req_data_o, req_op_o} !== '0) begin n_fail++; $display("FAIL rst_req_fields got=%h exp=0", {req_addr_o, req_data_o, req_op_o}); end
        n_run++; if (dtmcs_rdata_o !== 32'h0000_1071) begin n_fail++; $display("FAIL rst_dtmcs got=%h exp=00001071", dtmcs_rdata_o); end
        trst_i = 1'b0;
        tick();
    endtask

    task automatic test_write();
        dmi_t e;
        req_ready_i = 1'b1;
        exp_q.push_back({7'h10, 32'hDEADBEEF, 2'd2});
        dmi_upd({7'h10, 32'hDEADBEEF, 2'd2});
        @(negedge tck_i);
        n_run++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL wr_req_valid got=%b exp=1", req_valid_o); end
        n_run++; if (resp_ready_o !== 1'b0) begin n_fail++; $display("FAIL wr_resp_ready_in_req got=%b exp=0", resp_ready_o); end
        tick();
        @(negedge tck_i);
        n_run++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr_req_one_cycle got=%b exp=0", req_valid_o); end
        n_run++; if (dmi_rdata_o[1:0] !== 2'd3) begin n_fail++; $display("FAIL wr_busy_op got=%0d exp=3", dmi_rdata_o[1:0]); end
        resp(32'h1111_2222, 2'd0);
        @(negedge tck_i);
        e = {7'h10, 32'h1111_2222, 2'd0};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL wr_capture got=%h exp=%h", dmi_rdata_o, e); end
        n_run++; if (dtmcs_rdata_o[11:10] !== 2'd0) begin n_fail++; $display("FAIL wr_dmistat got=%0d exp=0", dtmcs_rdata_o[11:10]); end
    endtask

    task automatic test_read();
        dmi_t e;
        exp_q.push_back({7'h11, 32'h0, 2'd1});
        dmi_upd({7'h11, 32'h0, 2'd1});
        tick();
        resp(32'h1234_5678, 2'd0);
        @(negedge tck_i);
        e = {7'h11, 32'h1234_5678, 2'd0};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL rd_capture got=%h exp=%h", dmi_rdata_o, e); end
    endtask

    task automatic test_noop_priority();
        dmi_t e;
        int   f0;
        f0 = n_fire;
        dmi_upd({7'h30, 32'h5555_5555, 2'd0});
        dmi_upd({7'h31, 32'h6666_6666, 2'd3});
        dmi_wdata_i    = {7'h32, 32'h7777_7777, 2'd2};
        dmi_update_i   = 1'b1;
        dtmcs_wdata_i  = 32'h0001_0000;
        dtmcs_update_i = 1'b1;
        tick();
        dmi_update_i = 1'b0; dtmcs_update_i = 1'b0; dtmcs_wdata_i = '0;
        repeat (2) tick();
        @(negedge tck_i);
        n_run++; if (n_fire !== f0) begin n_fail++; $display("FAIL noop_prio_requests got=%0d exp=%0d", n_fire, f0); end
        e = {7'h11, 32'h1234_5678, 2'd0};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL noop_prio_rdata got=%h exp=%h", dmi_rdata_o, e); end
    endtask

    task automatic test_busy();
        dmi_t e;
        int   f0;
        req_ready_i = 1'b0;
        exp_q.push_back({7'h12, 32'hA5A5_A5A5, 2'd2});
        dmi_upd({7'h12, 32'hA5A5_A5A5, 2'd2});
        dmi_capture_i = 1'b1;
        @(negedge tck_i);
        n_run++; if (dmi_rdata_o[1:0] !== 2'd3) begin n_fail++; $display("FAIL busy_op_in_req got=%0d exp=3", dmi_rdata_o[1:0]); end
        tick();
        dmi_capture_i = 1'b0;
        @(negedge tck_i);
        n_run++; if ({req_valid_o, req_addr_o} !== {1'b1, 7'h12}) begin n_fail++; $display("FAIL busy_req_hold got=%h exp=%h", {req_valid_o, req_addr_o}, {1'b1, 7'h12}); end
        req_ready_i = 1'b1;
        tick();
        resp(32'h0BAD_0000, 2'd0);
        @(negedge tck_i);
        n_run++; if (dtmcs_rdata_o[11:10] !== 2'd3) begin n_fail++; $display("FAIL busy_sticky got=%0d exp=3", dtmcs_rdata_o[11:10]); end
        e = {7'h12, 32'h0BAD_0000, 2'd3};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL busy_rdata got=%h exp=%h", dmi_rdata_o, e); end
        f0 = n_fire;
        dmi_upd({7'h13, 32'h1, 2'd2});
        repeat (2) tick();
        @(negedge tck_i);
        n_run++; if (n_fire !== f0) begin n_fail++; $display("FAIL busy_update_blocked got=%0d exp=%0d", n_fire, f0); end
        dtmcs_wr(32'h0001_0000);
        @(negedge tck_i);
        n_run++; if (dtmcs_rdata_o[11:10] !== 2'd0) begin n_fail++; $display("FAIL busy_dmireset got=%0d exp=0", dtmcs_rdata_o[11:10]); end
    endtask

    task automatic test_sticky_fail();
        dmi_t e;
        int   f0;
        exp_q.push_back({7'h20, 32'h1, 2'd2});
        dmi_upd({7'h20, 32'h1, 2'd2});
        tick();
        resp(32'h55, 2'd2);
        @(negedge tck_i);
        n_run++; if (dtmcs_rdata_o[11:10] !== 2'd2) begin n_fail++; $display("FAIL fail_dmistat got=%0d exp=2", dtmcs_rdata_o[11:10]); end
        f0 = n_fire;
        dmi_upd({7'h21, 32'h0, 2'd1});
        repeat (3) tick();
        @(negedge tck_i);
        n_run++; if (n_fire !== f0) begin n_fail++; $display("FAIL fail_read_blocked got=%0d exp=%0d", n_fire, f0); end
        n_run++; if (dmi_rdata_o[1:0] !== 2'd2) begin n_fail++; $display("FAIL fail_rdata_op got=%0d exp=2", dmi_rdata_o[1:0]); end
        dtmcs_wr(32'h0001_0000);
        exp_q.push_back({7'h21, 32'h0, 2'd1});
        dmi_upd({7'h21, 32'h0, 2'd1});
        @(negedge tck_i);
        n_run++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL fail_after_reset_valid got=%b exp=1", req_valid_o); end
        tick();
        resp(32'h77, 2'd0);
        @(negedge tck_i);
        e = {7'h21, 32'h77, 2'd0};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL fail_after_reset_rdata got=%h exp=%h", dmi_rdata_o, e); end
    endtask

    task automatic test_hardreset();
        dmi_t e;
        exp_q.push_back({7'h40, 32'hBEEF, 2'd2});
        dmi_upd({7'h40, 32'hBEEF, 2'd2});
        tick();
        @(negedge tck_i);
        n_run++; if ({resp_ready_o, dmi_rdata_o[1:0]} !== 3'b111) begin n_fail++; $display("FAIL hr_in_resp got=%b exp=111", {resp_ready_o, dmi_rdata_o[1:0]}); end
        dtmcs_wr(32'h0002_0000);
        @(negedge tck_i);
        e = {7'h40, 32'h77, 2'd0};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL hr_idle got=%h exp=%h", dmi_rdata_o, e); end
        resp(32'hCAFE_0000, 2'd0);
        @(negedge tck_i);
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL hr_stale_discard got=%h exp=%h", dmi_rdata_o, e); end
        req_ready_i = 1'b0;
        dmi_upd({7'h41, 32'h9, 2'd2});
        @(negedge tck_i);
        n_run++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL hr_req_valid got=%b exp=1", req_valid_o); end
        dtmcs_wr(32'h0002_0000);
        @(negedge tck_i);
        n_run++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL hr_req_drop got=%b exp=0", req_valid_o); end
        req_ready_i = 1'b1;
    endtask

    task automatic test_timeout();
        dmi_t e;
        exp_q.push_back({7'h50, 32'h0, 2'd1});
        dmi_upd({7'h50, 32'h0, 2'd1});
        repeat (15) tick();
        @(negedge tck_i);
        n_run++; if (dmi_rdata_o[1:0] !== 2'd3) begin n_fail++; $display("FAIL to_busy_at_16 got=%0d exp=3", dmi_rdata_o[1:0]); end
`ifdef DTM_DMI_TIMEOUT_EN
        tick();
        @(negedge tck_i);
        e = {7'h50, 32'h77, 2'd2};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL to_abort got=%h exp=%h", dmi_rdata_o, e); end
        resp(32'hCAFE_0000, 2'd0);
        @(negedge tck_i);
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL to_stale_discard got=%h exp=%h", dmi_rdata_o, e); end
        dtmcs_wr(32'h0001_0000);
`else
        repeat (1000) tick();
        @(negedge tck_i);
        n_run++; if ({resp_ready_o, dmi_rdata_o[1:0]} !== 3'b111) begin n_fail++; $display("FAIL to_wait_forever got=%b exp=111", {resp_ready_o, dmi_rdata_o[1:0]}); end
        dtmcs_wr(32'h0002_0000);
        @(negedge tck_i);
        e = {7'h50, 32'h77, 2'd0};
        n_run++; if (dmi_rdata_o !== e) begin n_fail++; $display("FAIL to_hardreset_recover got=%h exp=%h", dmi_rdata_o, e); end
`endif
    endtask

    task automatic test_trst();
        req_ready_i = 1'b0;
        dmi_upd({7'h60, 32'h3, 2'd2});
        @(negedge tck_i);
        n_run++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL trst_pre_valid got=%b exp=1", req_valid_o); end
        #1 trst_i = 1'b1;
        #1;
        n_run++; if ({req_valid_o, resp_ready_o} !== 2'b01) begin n_fail++; $display("FAIL trst_handshake got=%b exp=01", {req_valid_o, resp_ready_o}); end
        n_run++; if (dmi_rdata_o !== '0) begin n_fail++; $display("FAIL trst_rdata got=%h exp=0", dmi_rdata_o); end
        n_run++; if ({req_addr_o, req_data_o, req_op_o} !== '0) begin n_fail++; $display("FAIL trst_req_fields got=%h exp=0", {req_addr_o, req_data_o, req_op_o}); end
        tick();
        trst_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_noop_priority();
        test_busy();
        test_sticky_fail();
        test_hardreset();
        test_timeout();
        test_trst();
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
